// File: rtl/gfau_op_sequencer.sv
// -----------------------------------------------------------------------------
// gfau_op_sequencer
//
// Control-side master for one GFAU instance. Takes GF(p) commands from the
// host (ECC point-operation FSM), fetches both operands from a local register
// file, presents them to the GFAU, waits for the result, writes it back and
// acknowledges the GFAU with a one-cycle done_from_control pulse.
//
// Handshakes (all sampled on the rising edge of i_clk):
//   command : a command transfers in the cycle where i_cmd_valid && o_cmd_ready.
//             o_cmd_ready depends only on FSM state (high in IDLE only), never on
//             i_cmd_valid. Fields must be stable while i_cmd_valid is high.
//   GFAU    : operands/op are held stable from accept until i_done_to_control.
//             The cycle with i_done_to_control=1 is the writeback cycle; the
//             following cycle carries o_done_from_control=1 and o_retire=1.
//             A skipped command (div by zero) never touches the GFAU and only
//             pulses o_retire.
//
// Configuration macro: GFAU_SEQ_TIMEOUT_EN
//   defined   : WAIT has a watchdog of TIMEOUT_CYCLES cycles; on expiry it sets
//               o_err_timeout and acknowledges without writeback.
//   undefined : WAIT waits indefinitely, o_err_timeout is tied to 0.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_reg_we/_waddr/_wdata            host write port of the register file
//   i_reg_raddr, o_reg_rdata          host combinational read port
//   i_prime_we, i_prime               prime register load (honoured in IDLE only)
//   i_cmd_valid, o_cmd_ready          command handshake
//   i_cmd_op/_src0/_src1/_dst         command fields (0 add,1 sub,2 mult,3 div)
//   o_in_0, o_in_1, o_prime,
//   o_operation_select                GFAU operand/op drive
//   o_done_from_control               acknowledge to the GFAU
//   i_result, i_done_to_control,
//   i_done_add/_sub/_mult/_div        GFAU result and done flags
//   o_retire                          one pulse per completed or skipped command
//   i_err_clr, o_err_div0,
//   o_err_proto, o_err_timeout        sticky error flags and their clear
//   o_dbg_state                       current FSM state (debug observation)
// -----------------------------------------------------------------------------
module gfau_op_sequencer #(
  parameter int DATA_W         = 32,
  parameter int REG_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW            = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_reg_we,
  input  logic [AW-1:0]     i_reg_waddr,
  input  logic [DATA_W-1:0] i_reg_wdata,
  input  logic [AW-1:0]     i_reg_raddr,
  output logic [DATA_W-1:0] o_reg_rdata,
  input  logic              i_prime_we,
  input  logic [DATA_W-1:0] i_prime,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [AW-1:0]     i_cmd_src0,
  input  logic [AW-1:0]     i_cmd_src1,
  input  logic [AW-1:0]     i_cmd_dst,
  output logic [DATA_W-1:0] o_in_0,
  output logic [DATA_W-1:0] o_in_1,
  output logic [DATA_W-1:0] o_prime,
  output logic [1:0]        o_operation_select,
  output logic              o_done_from_control,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_done_to_control,
  input  logic              i_done_add,
  input  logic              i_done_sub,
  input  logic              i_done_mult,
  input  logic              i_done_div,
  output logic              o_retire,
  input  logic              i_err_clr,
  output logic              o_err_div0,
  output logic              o_err_proto,
  output logic              o_err_timeout,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_SKIP = 2'd3
  } state_e;

  localparam logic [1:0] OP_DIV = 2'd3;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0] in0_q, in0_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [1:0]        opsel_q, opsel_d;
  logic [DATA_W-1:0] prime_q;
  logic              err_div0_q, err_proto_q;
  logic [DATA_W-1:0] regs_q [REG_DEPTH];

  logic              wb_en;
  logic              set_div0, set_proto, set_timeout;
  logic [3:0]        done_vec, done_exp;

  // Operand values as seen before the accept edge; src==dst is therefore safe.
  logic [DATA_W-1:0] src0_val, src1_val;
  assign src0_val = regs_q[i_cmd_src0];
  assign src1_val = regs_q[i_cmd_src1];

  // A well-behaved GFAU raises exactly the flag of the op it was given.
  assign done_vec = {i_done_div, i_done_mult, i_done_sub, i_done_add};
  assign done_exp = 4'b0001 << op_q;

`ifdef GFAU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_timeout_q;
`endif

  always_comb begin
    state_d             = state_q;
    op_d                = op_q;
    dst_d               = dst_q;
    in0_d               = in0_q;
    in1_d               = in1_q;
    opsel_d             = opsel_q;
    wb_en               = 1'b0;
    set_div0            = 1'b0;
    set_proto           = 1'b0;
    set_timeout         = 1'b0;
    o_cmd_ready         = 1'b0;
    o_done_from_control = 1'b0;
    o_retire            = 1'b0;
`ifdef GFAU_SEQ_TIMEOUT_EN
    cnt_d               = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          op_d  = i_cmd_op;
          dst_d = i_cmd_dst;
          if (i_cmd_op == OP_DIV && src1_val == '0) begin
            // GFAU outputs keep their previous values: nothing is issued.
            set_div0 = 1'b1;
            state_d  = S_SKIP;
          end else begin
            in0_d   = src0_val;
            in1_d   = src1_val;
            opsel_d = i_cmd_op;
            state_d = S_WAIT;
`ifdef GFAU_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (i_done_to_control) begin
          // Result is written even when the done flags look wrong.
          wb_en     = 1'b1;
          set_proto = (done_vec != done_exp);
          state_d   = S_ACK;
        end
`ifdef GFAU_SEQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          set_timeout = 1'b1;
          state_d     = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        o_done_from_control = 1'b1;
        o_retire            = 1'b1;
        state_d             = S_IDLE;
      end
      S_SKIP: begin
        o_retire = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      opsel_q     <= '0;
      prime_q     <= '0;
      err_div0_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      opsel_q     <= opsel_d;
      // The modulus is frozen while a command is in flight.
      if (i_prime_we && state_q == S_IDLE) prime_q <= i_prime;
      // A newly raised error beats a simultaneous clear.
      err_div0_q  <= set_div0  | (err_div0_q  & ~i_err_clr);
      err_proto_q <= set_proto | (err_proto_q & ~i_err_clr);
    end
  end

`ifdef GFAU_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= set_timeout | (err_timeout_q & ~i_err_clr);
    end
  end
  assign o_err_timeout = err_timeout_q;
`else
  assign o_err_timeout = 1'b0;
  // set_timeout is only driven by the watchdog path.
  logic unused_timeout;
  assign unused_timeout = set_timeout;
`endif

  // Register file: GFAU writeback has priority over a host write to the same
  // entry; host writes to any other entry proceed in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        if (wb_en && dst_q == AW'(i))
          regs_q[i] <= i_result;
        else if (i_reg_we && i_reg_waddr == AW'(i))
          regs_q[i] <= i_reg_wdata;
      end
    end
  end

  assign o_reg_rdata        = regs_q[i_reg_raddr];
  assign o_in_0             = in0_q;
  assign o_in_1             = in1_q;
  assign o_prime            = prime_q;
  assign o_operation_select = opsel_q;
  assign o_err_div0         = err_div0_q;
  assign o_err_proto        = err_proto_q;
  assign o_dbg_state        = state_q;

endmodule
